// File: rtl/parking_gate_arbiter_pkg.sv
// Shared types for the parking gate arbiter: gate FSM encoding and lane direction codes.
package parking_gate_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2
  } gate_state_e;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Lane request/grant bundle between the lane controllers (master) and the gate arbiter (slave).
interface parking_gate_arbiter_if #(
  parameter int N_LANES  = 4,
  parameter int CAPACITY = 4
);
  localparam int CNT_W = $clog2(CAPACITY + 1);

  logic [N_LANES-1:0] req;
  logic [N_LANES-1:0] dir;
  logic [N_LANES-1:0] grant;
  logic               gate_open;
  logic [CNT_W-1:0]   occupancy;
  logic               full;
  logic               empty;
  logic               busy;

  modport master (output req, dir, input grant, gate_open, occupancy, full, empty, busy);
  modport slave  (input req, dir, output grant, gate_open, occupancy, full, empty, busy);
endinterface

// File: rtl/parking_gate_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first eligible lane at or after ptr_i.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  int idx;

  // Walk from farthest to nearest so the lane closest to the pointer wins last.
  always_comb begin
    gnt_o = '0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % N;
      if (elig_i[idx[PW-1:0]]) begin
        gnt_o = '0;
        gnt_o[idx[PW-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared barrier gate sequencer and authoritative occupancy counter.
// Build option EXIT_PRIORITY_EN: eligible exit lanes win over enter lanes in arbitration.
module parking_gate_arbiter
  import parking_gate_arbiter_pkg::*;
#(
  parameter int N_LANES     = 4,
  parameter int CAPACITY    = 4,
  parameter int OPEN_CYCLES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  parking_gate_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int PW    = $clog2(N_LANES);
  localparam int OW    = $clog2(OPEN_CYCLES);

  gate_state_e        state_q;
  logic [N_LANES-1:0] grant_q;
  logic               gate_q;
  logic [OW-1:0]      cnt_q;
  logic               dir_q;
  logic               abort_q;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               full_q, empty_q;
  logic [PW-1:0]      ptr_q, ptr_d;

  logic [N_LANES-1:0] elig_enter, elig_exit, arb_gnt;
  logic               own_req;

  assign elig_enter = bus.req & ~bus.dir & {N_LANES{~full_q}};
  assign elig_exit  = bus.req &  bus.dir & {N_LANES{~empty_q}};
  assign own_req    = |(grant_q & bus.req);

`ifdef EXIT_PRIORITY_EN
  logic [N_LANES-1:0] gnt_exit, gnt_enter;
  rr_arbiter #(.N(N_LANES)) u_arb_exit  (.elig_i(elig_exit),  .ptr_i(ptr_q), .gnt_o(gnt_exit));
  rr_arbiter #(.N(N_LANES)) u_arb_enter (.elig_i(elig_enter), .ptr_i(ptr_q), .gnt_o(gnt_enter));
  assign arb_gnt = (|gnt_exit) ? gnt_exit : gnt_enter;
`else
  rr_arbiter #(.N(N_LANES)) u_arb (.elig_i(elig_enter | elig_exit), .ptr_i(ptr_q), .gnt_o(arb_gnt));
`endif

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N_LANES; i++)
      if (arb_gnt[i]) ptr_d = (i == N_LANES - 1) ? '0 : PW'(i + 1);
  end

  always_comb begin
    occ_d = occ_q;
    if (state_q == ST_CLOSE && !abort_q)
      occ_d = (dir_q == DIR_EXIT) ? occ_q - CNT_W'(1) : occ_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gate_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= DIR_ENTER;
      abort_q <= 1'b0;
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (|arb_gnt) begin
          state_q <= ST_OPEN;
          grant_q <= arb_gnt;
          gate_q  <= 1'b1;
          cnt_q   <= OW'(OPEN_CYCLES - 1);
          dir_q   <= |(arb_gnt & bus.dir);
          abort_q <= 1'b0;
          ptr_q   <= ptr_d;
        end
        ST_OPEN: begin
          // A lane withdrawing mid-window closes early and is not counted.
          if (!own_req || cnt_q == '0) begin
            state_q <= ST_CLOSE;
            grant_q <= '0;
            gate_q  <= 1'b0;
            abort_q <= !own_req;
          end else begin
            cnt_q <= cnt_q - OW'(1);
          end
        end
        ST_CLOSE: begin
          state_q <= ST_IDLE;
          occ_q   <= occ_d;
          full_q  <= (occ_d == CNT_W'(CAPACITY));
          empty_q <= (occ_d == '0);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i)
    if (!rst_i) assert (occ_q <= CNT_W'(CAPACITY));

  assign bus.grant     = grant_q;
  assign bus.gate_open = gate_q;
  assign bus.occupancy = occ_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: vector table for a single entry, then multi-cycle sequences.
module tb_parking_gate_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  parking_gate_arbiter_if #(.N_LANES(4), .CAPACITY(4)) bus ();

  parking_gate_arbiter #(.N_LANES(4), .CAPACITY(4), .OPEN_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] dir;
    logic [3:0] grant;
    logic       gate;
    logic [2:0] occ;
    logic       full;
    logic       empty;
    logic       busy;
  } vec_t;

  vec_t tv [12];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for grant change", nm);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.dir = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string nm);
    for (int k = 0; k < 40; k++) begin
      if (bus.grant != '0) return;
      step();
    end
    timeout(nm);
  endtask

  task automatic wait_nogrant(input string nm);
    for (int k = 0; k < 40; k++) begin
      if (bus.grant == '0) return;
      step();
    end
    timeout(nm);
  endtask

  task automatic do_txn(input logic [1:0] lane, input logic d, input logic [2:0] exp_occ);
    bus.req[lane] = 1'b1;
    bus.dir[lane] = d;
    wait_grant("txn wait");
    chk("txn grant", 32'(bus.grant), 32'(4'b0001 << lane));
    wait_nogrant("txn close");
    bus.req[lane] = 1'b0;
    step();
    chk("txn occupancy", 32'(bus.occupancy), 32'(exp_occ));
  endtask

  initial begin
    int prev;
    rst = 1'b1;
    bus.req = '0;
    bus.dir = '0;

    // Test 1: single entry on lane 0
    tv[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i <= 8; i++)
      tv[i] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
    tv[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tv[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      rst     = tv[i].rst;
      bus.req = tv[i].req;
      bus.dir = tv[i].dir;
      step();
      chk($sformatf("t1 row%0d", i),
          32'({bus.grant, bus.gate_open, bus.occupancy, bus.full, bus.empty, bus.busy}),
          32'({tv[i].grant, tv[i].gate, tv[i].occ, tv[i].full, tv[i].empty, tv[i].busy}));
    end

    // Test 2: four simultaneous entries, round-robin, 10 cycles apart
    do_reset();
    bus.req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant("t2 wait");
      chk("t2 grant", 32'(bus.grant), 32'(4'b0001 << k));
      if (k > 0) chk("t2 spacing", 32'(cyc - prev), 32'd10);
      prev = cyc;
      wait_nogrant("t2 close");
      bus.req[k] = 1'b0;
    end
    step();
    chk("t2 occupancy", 32'(bus.occupancy), 32'd4);
    chk("t2 full", 32'(bus.full), 32'd1);

    // Test 3: full lot, exit on lane 2 must go before enter on lane 1
    bus.dir = 4'b0100;
    bus.req = 4'b0110;
    wait_grant("t3 wait a");
    chk("t3 exit first", 32'(bus.grant), 32'(4'b0100));
    wait_nogrant("t3 close a");
    bus.req[2] = 1'b0;
    step();
    chk("t3 occ after exit", 32'(bus.occupancy), 32'd3);
    chk("t3 full after exit", 32'(bus.full), 32'd0);
    wait_grant("t3 wait b");
    chk("t3 enter second", 32'(bus.grant), 32'(4'b0010));
    wait_nogrant("t3 close b");
    bus.req[1] = 1'b0;
    step();
    chk("t3 occ after enter", 32'(bus.occupancy), 32'd4);
    chk("t3 full again", 32'(bus.full), 32'd1);

    // Test 4: exit from occupancy 2 aborted in open cycle 3
    bus.dir = '0;
    do_txn(2'd0, 1'b1, 3'd3);
    do_txn(2'd0, 1'b1, 3'd2);
    bus.req[0] = 1'b1;
    bus.dir[0] = 1'b1;
    wait_grant("t4 wait");
    step();
    step();
    bus.req[0] = 1'b0;
    step();
    chk("t4 close state", 32'({bus.grant, bus.gate_open, bus.busy}), 32'({4'b0000, 1'b0, 1'b1}));
    step();
    chk("t4 occupancy kept", 32'({bus.occupancy, bus.busy}), 32'({3'd2, 1'b0}));

    // Test 5: reset in open cycle 5 at occupancy 3
    bus.dir = '0;
    do_txn(2'd1, 1'b0, 3'd3);
    bus.req[1] = 1'b1;
    wait_grant("t5 wait");
    for (int k = 0; k < 4; k++) step();
    chk("t5 still open", 32'({bus.grant, bus.gate_open}), 32'({4'b0010, 1'b1}));
    rst = 1'b1;
    step();
    chk("t5 after reset",
        32'({bus.grant, bus.gate_open, bus.occupancy, bus.busy, bus.empty}),
        32'({4'b0000, 1'b0, 3'd0, 1'b0, 1'b1}));
    rst = 1'b0;
    bus.req = '0;

    // Test 6: pointer at lane 0, lane0 enter vs lane3 exit
    do_reset();
    do_txn(2'd3, 1'b0, 3'd1);
    bus.dir = 4'b1000;
    bus.req = 4'b1001;
    wait_grant("t6 wait");
`ifdef EXIT_PRIORITY_EN
    chk("t6 first grant", 32'(bus.grant), 32'(4'b1000));
`else
    chk("t6 first grant", 32'(bus.grant), 32'(4'b0001));
`endif
    bus.req = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
